// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: CPU-visible register block for the push-buttons and
// the 4-digit seven-segment display, all on the CPU clock.
module io_mmio_ctrl #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnU,
    input  logic        btnD,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    typedef enum logic [3:0] {
        DIG0 = 4'b1110,
        DIG1 = 4'b1101,
        DIG2 = 4'b1011,
        DIG3 = 4'b0111
    } dig_e;

    logic [3:0]    btn_raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [3:0]    evt;
    logic [DW-1:0] deb_cnt [4];
    logic [3:0]    deb_hit;
    logic [3:0]    rise;

    logic [31:0]   disp;
    logic [2:0]    ctrl;
    logic [3:0]    sel_oh;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   rd_mux;
    logic [3:0]    evt_clr;

    logic [SW-1:0] scan_cnt;
    dig_e          dig;
    logic          page;
    logic [15:0]   half;
    logic [3:0]    nib;
    logic          addr_unused;

    assign btn_raw     = {btnD, btnU, btnR, btnL};
    assign addr_unused = ^addr[1:0];
    assign sel_oh      = 4'b0001 << addr[3:2];
    assign rd_en       = req & ~we;
    assign wr_en       = req & we;
    assign evt_clr     = {4{rd_en & sel_oh[3]}};
    assign rise        = deb_hit & sync2;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b0100111;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_hit[i] = (sync2[i] != stable[i]) &&
                         (deb_cnt[i] == DEB_LAST);
        end
    end

    // A hit always means synced differs from stable, so toggling
    // the stable bit adopts the synced level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            stable <= stable ^ deb_hit;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i] || deb_hit[i])
                    deb_cnt[i] <= '0;
                else
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            sel_oh[0]: rd_mux = disp;
            sel_oh[1]: rd_mux = {29'd0, ctrl};
            sel_oh[2]: rd_mux = {28'd0, stable};
            sel_oh[3]: rd_mux = {28'd0, evt};
            default:   rd_mux = '0;
        endcase
    end

    // Set wins over clear-on-read for the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ack   <= 1'b0;
            rdata <= '0;
            disp  <= '0;
            ctrl  <= '0;
            evt   <= '0;
        end else begin
            ack   <= req;
            rdata <= rd_en ? rd_mux : '0;
            evt   <= (evt & ~evt_clr) | rise;
            if (wr_en && sel_oh[0]) disp <= wdata;
            if (wr_en && sel_oh[1]) ctrl <= wdata[2:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt <= '0;
            dig      <= DIG0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            case (dig)
                DIG0:    dig <= DIG1;
                DIG1:    dig <= DIG2;
                DIG2:    dig <= DIG3;
                default: dig <= DIG0;
            endcase
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        page = ctrl[1] ? stable[0] : ctrl[0];
        half = page ? disp[31:16] : disp[15:0];
        nib  = half[3:0];
        case (dig)
            DIG1:    nib = half[7:4];
            DIG2:    nib = half[11:8];
            DIG3:    nib = half[15:12];
            default: nib = half[3:0];
        endcase
        an  = ctrl[2] ? 4'b1111 : dig;
        seg = ctrl[2] ? 7'b1111111 : hex7(nib);
    end

endmodule
